mac_stg0_unpack: RTL and testbench
==================================

// Module: mac_stg0_unpack
// PURPOSE
//  Input-side counterpart of the MAC output packer: unpacks 16-bit FP activations
//  {sgn, exp[4:0], frac[9:0]} (bias 15) into the sign / unbiased-exponent /
//  hidden-1 mantissa fields consumed by MAC stage 1.
//  Tracks the group maximum exponent per convolution window, for later alignment
//  and re-biasing. Uses the same i_inhibit stall semantics as the MAC stages.
// PARAMETERS
//  GRP_N   9   activations per group (3x3 window); legal range 1..63
//  BIAS    15  exponent bias of the input format
// PORTS
//  i_clk        in   1   clock, rising edge
//  i_rst_n      in   1   reset, asynchronous, active-low
//  i_inhibit    in   1   pipeline stall; 1 = every register holds
//  i_valid      in   1   i_act carries a valid activation
//  i_act        in   16  FP16 activation {sgn, exp[4:0], frac[9:0]}
//  o_valid      out  1   decoded fields valid
//  o_sgn        out  1   sign
//  o_exp        out  6   unbiased exponent, two's complement (exp - BIAS)
//  o_frac       out  11  mantissa with hidden 1 at bit 10
//  o_zero       out  1   operand is zero (incl. flushed denormal)
//  o_sat        out  1   input was Inf/NaN, saturated to max finite
//  o_grp_last   out  1   this output is the GRP_N-th of its group
//  o_max_exp    out  6   signed max o_exp over the group; valid when o_grp_last=1
// BEHAVIOUR
//  - Reset: all outputs 0. Group counter = 0. Running max = 6'h31 (-15).
//  - Latency: 2 cycles. Stage A registers i_valid/i_act. Stage B registers the
//    decoded fields. Bubbles (i_valid=0) propagate as o_valid=0.
//  - i_inhibit=1: stage A, stage B, counter and running max all hold. Outputs are
//    stable. i_act is not sampled.
//  - Decode (stage A -> B):
//    - exp==0 (zero/denormal): flush to zero. o_zero=1, o_exp=6'h31, o_frac=0.
//      Sign is kept.
//    - exp==31 (Inf/NaN): o_sat=1, o_exp=+15, o_frac=11'h7FF. Sign is kept.
//    - Otherwise: o_exp = exp-15 (range -14..+15), o_frac = {1'b1, frac}.
//  - Fields are don't-care when o_valid=0; the implementation drives them to 0.
//  - Group tracking advances only on cycles where stage B loads a valid item
//    (!i_inhibit && stage-A valid).
//    - cnt increments; at cnt==GRP_N-1 the item is flagged o_grp_last=1 and
//      cnt wraps to 0.
//    - Running max: signed compare of o_exp. Zero operands do not raise it
//      (their -15 equals the init value).
//    - o_max_exp = max including the current item, presented in the same cycle
//      as o_grp_last.
//    - On that same load the running max re-initialises to -15 for the next
//      group. There is no lost cycle between groups.
//    - An all-zero group reports o_max_exp = 6'h31.
//  - o_max_exp holds its last value while o_grp_last=0.
//  - Reset mid-group: discards the partial group. Counter and max return to
//    their initial values asynchronously.
// STRUCTURE
//  - Package mac_pkg:
//    - FP16 field widths (EXP_W=5, FRAC_W=10)
//    - INT_EXP_W=6
//    - EXP_ZERO=6'h31, EXP_SAT=6'h0F, FRAC_SAT=11'h7FF
//    - decoded-operand struct {sgn, exp, frac, zero, sat}
//  - Sub-module fp16_field_decode: purely combinational i_act -> decoded struct.
//    It is reused later by the weight-path checker.
//  - The top holds the two pipeline stages, the group counter and the max
//    tracker.
// TESTING
//  1. 16'h3C00 then 16'hC100, no stall.
//     -> 2 cycles later: {sgn0, exp 0, frac 11'h400}, then {sgn1, exp +1, frac 11'h500}.
//  2. 16'h0000, 16'h0200, 16'h7C00, 16'hFE00.
//     -> zero (exp 6'h31), zero (denormal flushed), sat sgn0, sat sgn1 (exp 15, frac 11'h7FF).
//  3. Nine back-to-back items: 16'h3C00 x4, 16'h4800, 16'h3800 x4.
//     -> o_grp_last only on the 9th output, o_max_exp=3.
//     -> Next group of 16'h3800 x9 reports -1 (6'h3F).
//  4. i_inhibit=1 for 3 cycles mid-group with i_act toggling.
//     -> outputs and counter frozen; no item lost or duplicated.
//     -> o_grp_last still lands on the 9th valid item.
//  5. Bubbles (i_valid=0) interleaved with group items -> counter ignores them.
//     Then i_rst_n low after 5 items -> o_valid=0 at once.
//     -> The next 9 items form a fresh group.
//  6. Nine zeros -> o_max_exp=6'h31 with o_grp_last=1.

Source files
------------

// File: rtl/mac_stg0_unpack_pkg.sv
// Shared FP16 field widths, constants and decoded-operand bundle
// for the MAC input unpack stage and the weight-path checker.
package mac_pkg;

    localparam int EXP_W     = 5;
    localparam int FRAC_W    = 10;
    localparam int INT_EXP_W = 6;
    localparam int MANT_W    = FRAC_W + 1;

    localparam logic [INT_EXP_W-1:0] EXP_ZERO = 6'h31;
    localparam logic [INT_EXP_W-1:0] EXP_SAT  = 6'h0F;
    localparam logic [MANT_W-1:0]    FRAC_SAT = 11'h7FF;

    typedef struct packed {
        logic                 sgn;
        logic [INT_EXP_W-1:0] exp;
        logic [MANT_W-1:0]    frac;
        logic                 zero;
        logic                 sat;
    } dec_t;

    function automatic logic [INT_EXP_W-1:0] exp_max(
        input logic [INT_EXP_W-1:0] a,
        input logic [INT_EXP_W-1:0] b
    );
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/mac_stg0_unpack_if.sv
// Activation in / decoded-operand out bundle of the MAC unpack stage.
// slave = the unpack block, master = whoever feeds and consumes it.
interface mac_stg0_unpack_if;

    logic        i_valid;
    logic [15:0] i_act;
    logic        o_valid;
    logic        o_sgn;
    logic [5:0]  o_exp;
    logic [10:0] o_frac;
    logic        o_zero;
    logic        o_sat;
    logic        o_grp_last;
    logic [5:0]  o_max_exp;

    modport slave (
        input  i_valid,
        input  i_act,
        output o_valid,
        output o_sgn,
        output o_exp,
        output o_frac,
        output o_zero,
        output o_sat,
        output o_grp_last,
        output o_max_exp
    );

    modport master (
        output i_valid,
        output i_act,
        input  o_valid,
        input  o_sgn,
        input  o_exp,
        input  o_frac,
        input  o_zero,
        input  o_sat,
        input  o_grp_last,
        input  o_max_exp
    );

endinterface

// File: rtl/mac_stg0_unpack_decode.sv
// Combinational FP16 -> {sgn, unbiased exp, hidden-1 mantissa} decode.
// Denormals flush to zero; Inf/NaN saturate to the largest finite value.
module fp16_field_decode
    import mac_pkg::*;
#(
    parameter int BIAS = 15
) (
    input  logic [15:0] i_act,
    output dec_t        o_dec
);

    logic [EXP_W-1:0] e;

    always_comb begin
        e = i_act[14:10];
        o_dec = '0;
        o_dec.sgn = i_act[15];
        unique case (1'b1)
            (e == '0): begin
                o_dec.zero = 1'b1;
                o_dec.exp  = EXP_ZERO;
                o_dec.frac = '0;
            end
            (e == '1): begin
                o_dec.sat  = 1'b1;
                o_dec.exp  = EXP_SAT;
                o_dec.frac = FRAC_SAT;
            end
            default: begin
                o_dec.exp  = {1'b0, e} - 6'(BIAS);
                o_dec.frac = {1'b1, i_act[9:0]};
            end
        endcase
    end

endmodule

// File: rtl/mac_stg0_unpack.sv
// MAC stage 0: two-stage FP16 activation unpack with per-window
// group counter and running signed max exponent.
module mac_stg0_unpack
    import mac_pkg::*;
#(
    parameter int GRP_N = 9,
    parameter int BIAS  = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inhibit,
    mac_stg0_unpack_if.slave bus
);

    localparam logic [5:0] LAST_CNT = 6'(GRP_N - 1);

    logic        a_vld_q, a_vld_d;
    logic [15:0] a_act_q, a_act_d;

    logic        b_vld_q, b_vld_d;
    dec_t        b_dec_q, b_dec_d;
    logic        b_last_q, b_last_d;
    logic [5:0]  b_max_q, b_max_d;

    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  run_max_q, run_max_d;

    dec_t        dec;
    logic        load;
    logic        last;
    logic [5:0]  cur_max;

    fp16_field_decode #(
        .BIAS (BIAS)
    ) u_dec (
        .i_act (a_act_q),
        .o_dec (dec)
    );

    always_comb begin
        a_vld_d = a_vld_q;
        a_act_d = a_act_q;
        if (!i_inhibit) begin
            a_vld_d = bus.i_valid;
            a_act_d = bus.i_valid ? bus.i_act : '0;
        end
    end

    // group bookkeeping only moves when a real item lands in stage B
    always_comb begin
        load    = !i_inhibit && a_vld_q;
        last    = (cnt_q == LAST_CNT);
        cur_max = exp_max(run_max_q, dec.exp);

        b_vld_d   = b_vld_q;
        b_dec_d   = b_dec_q;
        b_last_d  = b_last_q;
        b_max_d   = b_max_q;
        cnt_d     = cnt_q;
        run_max_d = run_max_q;

        if (!i_inhibit) begin
            b_vld_d  = a_vld_q;
            b_dec_d  = a_vld_q ? dec : '0;
            b_last_d = load && last;
        end

        if (load) begin
            if (last) begin
                cnt_d     = '0;
                run_max_d = EXP_ZERO;
                b_max_d   = cur_max;
            end else begin
                cnt_d     = cnt_q + 6'd1;
                run_max_d = cur_max;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_vld_q   <= 1'b0;
            a_act_q   <= '0;
            b_vld_q   <= 1'b0;
            b_dec_q   <= '0;
            b_last_q  <= 1'b0;
            b_max_q   <= '0;
            cnt_q     <= '0;
            run_max_q <= EXP_ZERO;
        end else begin
            a_vld_q   <= a_vld_d;
            a_act_q   <= a_act_d;
            b_vld_q   <= b_vld_d;
            b_dec_q   <= b_dec_d;
            b_last_q  <= b_last_d;
            b_max_q   <= b_max_d;
            cnt_q     <= cnt_d;
            run_max_q <= run_max_d;
        end
    end

    assign bus.o_valid    = b_vld_q;
    assign bus.o_sgn      = b_dec_q.sgn;
    assign bus.o_exp      = b_dec_q.exp;
    assign bus.o_frac     = b_dec_q.frac;
    assign bus.o_zero     = b_dec_q.zero;
    assign bus.o_sat      = b_dec_q.sat;
    assign bus.o_grp_last = b_last_q;
    assign bus.o_max_exp  = b_max_q;

endmodule

// File: tb/tb_mac_stg0_unpack.sv
// Directed bench for mac_stg0_unpack: vector tables plus hand-written
// stall, bubble and mid-group reset sequences.
module tb_mac_stg0_unpack;

    logic clk;
    logic rst_n;
    logic inhibit;
    int   checks;
    int   errors;
    int   seen;

    mac_stg0_unpack_if bus ();

    mac_stg0_unpack #(
        .GRP_N (9),
        .BIAS  (15)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_inhibit (inhibit),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] act;
        logic [21:0] e;
        logic [5:0]  emax;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [21:0] pk(
        input logic v, input logic s, input logic [5:0] x,
        input logic [10:0] f, input logic z, input logic st,
        input logic l
    );
        return {v, s, x, f, z, st, l};
    endfunction

    function automatic logic [21:0] outs();
        return {bus.o_valid, bus.o_sgn, bus.o_exp, bus.o_frac,
                bus.o_zero, bus.o_sat, bus.o_grp_last};
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic add(input logic v, input logic [15:0] act,
                       input logic [21:0] e, input logic [5:0] emax);
        vec_t r;
        r.v = v;
        r.act = act;
        r.e = e;
        r.emax = emax;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic inh, input logic v, input logic [15:0] act);
        @(negedge clk);
        inhibit = inh;
        bus.i_valid = v;
        bus.i_act = act;
        @(posedge clk);
        #1;
    endtask

    task automatic run_tbl(input string name);
        int n;
        n = tbl.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(1'b0, tbl[i].v, tbl[i].act);
            else drive(1'b0, 1'b0, 16'h0);
            if (i >= 1) begin
                chk($sformatf("%s[%0d]", name, i - 1), 32'(outs()), 32'(tbl[i-1].e));
                if (tbl[i-1].e[0])
                    chk($sformatf("%s_max[%0d]", name, i - 1),
                        32'(bus.o_max_exp), 32'(tbl[i-1].emax));
            end
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        inhibit = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_act = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_max", 32'(bus.o_max_exp), 32'h0);
        rst_n = 1'b1;
    endtask

    // item k carries unbiased exponent k, so max over 0..8 is 8
    function automatic logic [15:0] act_k(input int k);
        return {1'b0, 5'(15 + k), 10'h0};
    endfunction

    task automatic mon();
        if (bus.o_valid) begin
            chk($sformatf("item%0d", seen),
                32'({bus.o_exp, bus.o_frac, bus.o_grp_last}),
                32'({6'(seen), 11'h400, seen == 8}));
            if (seen == 8) chk("grp_max", 32'(bus.o_max_exp), 32'd8);
            seen++;
        end
    endtask

    task automatic grp_run(input int n, input bit bub, input bit stall,
                           input bit drain);
        logic [21:0] snap;
        logic [5:0]  smax;
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b1, act_k(k));
            mon();
            if (bub) begin
                drive(1'b0, 1'b0, 16'hABCD);
                mon();
            end
            if (stall && k == 3) begin
                snap = outs();
                smax = bus.o_max_exp;
                for (int j = 0; j < 3; j++) begin
                    drive(1'b1, 1'b1, (j % 2 == 1) ? 16'h7C00 : 16'h0000);
                    chk("stall_hold", 32'(outs()), 32'(snap));
                    chk("stall_max", 32'(bus.o_max_exp), 32'(smax));
                end
            end
        end
        if (drain) begin
            repeat (2) begin
                drive(1'b0, 1'b0, 16'h0);
                mon();
            end
            chk("item_count", 32'(seen), 32'(n));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        seen = 0;
        rst_n = 1'b0;
        inhibit = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_act = '0;

        do_reset();
        add(1, 16'h3C00, pk(1, 0, 6'h00, 11'h400, 0, 0, 0), 6'h00);
        add(1, 16'hC100, pk(1, 1, 6'h01, 11'h500, 0, 0, 0), 6'h00);
        add(1, 16'h0000, pk(1, 0, 6'h31, 11'h000, 1, 0, 0), 6'h00);
        add(1, 16'h0200, pk(1, 0, 6'h31, 11'h000, 1, 0, 0), 6'h00);
        add(1, 16'h7C00, pk(1, 0, 6'h0F, 11'h7FF, 0, 1, 0), 6'h00);
        add(1, 16'hFE00, pk(1, 1, 6'h0F, 11'h7FF, 0, 1, 0), 6'h00);
        run_tbl("decode");

        do_reset();
        for (int i = 0; i < 4; i++)
            add(1, 16'h3C00, pk(1, 0, 6'h00, 11'h400, 0, 0, 0), 6'h00);
        add(1, 16'h4800, pk(1, 0, 6'h03, 11'h400, 0, 0, 0), 6'h00);
        for (int i = 0; i < 4; i++)
            add(1, 16'h3800, pk(1, 0, 6'h3F, 11'h400, 0, 0, i == 3), 6'h03);
        for (int i = 0; i < 9; i++)
            add(1, 16'h3800, pk(1, 0, 6'h3F, 11'h400, 0, 0, i == 8), 6'h3F);
        run_tbl("grp");

        do_reset();
        seen = 0;
        grp_run(9, 1'b0, 1'b1, 1'b1);

        do_reset();
        seen = 0;
        grp_run(9, 1'b1, 1'b0, 1'b1);

        seen = 0;
        grp_run(5, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.o_valid), 32'h0);
        chk("async_rst_outs", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        grp_run(9, 1'b0, 1'b0, 1'b1);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            add(1, (i % 2 == 1) ? 16'h8000 : 16'h0000,
                pk(1, i % 2 == 1, 6'h31, 11'h000, 1, 0, i == 8), 6'h31);
            if (i == 4) add(0, 16'h3C00, 22'h0, 6'h00);
        end
        run_tbl("zeros");
        drive(1'b0, 1'b0, 16'h0);
        chk("max_hold", 32'({bus.o_grp_last, bus.o_max_exp}), 32'({1'b0, 6'h31}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
